// File: rtl/y86_pkg.sv
// Shared constants, state encoding and helpers for the Y86-64 SEQ controller.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WB,
    S_PCUPD,
    S_HALT
  } state_t;

  function automatic logic needs_dmem(input logic [3:0] ic);
    return ic inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
                      ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
  endfunction

endpackage

// File: rtl/seq_mem_wait.sv
// Request/ack wait tracker with a bounded timeout.
// The ack wins over a timeout expiring in the same cycle.
module seq_mem_wait #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic done,
  output logic fault
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !req) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done  = req & ack;
  assign fault = req & ~ack & (cnt == LAST);

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage controller for the Y86-64 SEQ datapath.
// Owns the PC, processor status and the per-stage strobes.
module seq_stage_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      pc_next,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             wb_en,
  output logic [63:0]      pc,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state;
  logic [3:0] icode_q;
  logic       imem_done;
  logic       imem_fault;
  logic       dmem_done;
  logic       dmem_fault;

  // Strobes and requests decode straight from the state register.
  assign fetch_en   = (state == S_FETCH);
  assign decode_en  = (state == S_DECODE);
  assign execute_en = (state == S_EXECUTE);
  assign memory_en  = (state == S_MEMORY);
  assign wb_en      = (state == S_WB);
  assign halted     = (state == S_HALT);
  assign imem_req   = fetch_en;
  assign dmem_req   = memory_en && needs_dmem(icode_q);

  seq_mem_wait #(.TIMEOUT(TIMEOUT)) u_imem_wait (
    .clock (clock),
    .reset (reset),
    .req   (imem_req),
    .ack   (imem_ack),
    .done  (imem_done),
    .fault (imem_fault)
  );

  seq_mem_wait #(.TIMEOUT(TIMEOUT)) u_dmem_wait (
    .clock (clock),
    .reset (reset),
    .req   (dmem_req),
    .ack   (dmem_ack),
    .done  (dmem_done),
    .fault (dmem_fault)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stat      <= STAT_AOK;
      icode_q   <= ICODE_HALT;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_done) begin
            icode_q <= icode;
            if (imem_error) begin
              stat  <= STAT_ADR;
              state <= S_HALT;
            end else if (!instr_valid) begin
              stat  <= STAT_INS;
              state <= S_HALT;
            end else begin
              state <= S_DECODE;
            end
          end else if (imem_fault) begin
            stat  <= STAT_ADR;
            state <= S_HALT;
          end
        end
        S_DECODE:  state <= S_EXECUTE;
        S_EXECUTE: state <= S_MEMORY;
        S_MEMORY: begin
          if (!needs_dmem(icode_q)) begin
            state <= S_WB;
          end else if (dmem_done) begin
            if (dmem_error) begin
              stat  <= STAT_ADR;
              state <= S_HALT;
            end else begin
              state <= S_WB;
            end
          end else if (dmem_fault) begin
            stat  <= STAT_ADR;
            state <= S_HALT;
          end
        end
        S_WB: state <= S_PCUPD;
        S_PCUPD: begin
          pc        <= pc_next;
          instr_cnt <= instr_cnt + CNT_W'(1);
          if (icode_q == ICODE_HALT) begin
            stat  <= STAT_HLT;
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Bench for seq_stage_sequencer: directed scenarios plus random
// programs scored against a per-instruction cycle/status model.
module tb_seq_stage_sequencer;

  localparam int TMO    = 16;
  localparam int BUDGET = 600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc_next = '0;
  logic [3:0]  icode = '0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        dmem_req;
  logic        dmem_ack = 1'b0;
  logic        dmem_error = 1'b0;
  logic        fetch_en, decode_en, execute_en, memory_en, wb_en;
  logic [63:0] pc;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int vectors = 0;
  int miscompares = 0;

  seq_stage_sequencer #(
    .RESET_PC (64'h0),
    .TIMEOUT  (TMO),
    .CNT_W    (32)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .pc_next     (pc_next),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .dmem_error  (dmem_error),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .execute_en  (execute_en),
    .memory_en   (memory_en),
    .wb_en       (wb_en),
    .pc          (pc),
    .stat        (stat),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  always #5 clk = ~clk;

  // Program table: one entry per fetched instruction.
  logic [3:0]  p_icode [8];
  bit          p_valid [8];
  bit          p_ierr  [8];
  bit          p_derr  [8];
  int          p_idly  [8];
  int          p_ddly  [8];
  logic [63:0] p_npc   [8];

  bit stray_iack = 0;
  bit stray_dack = 0;

  // Memory responder: ack arrives on the Nth cycle of a request.
  int fidx = 0, cur = 0, icyc = 0, dcyc = 0;
  bit ireq_q = 0;
  always @(negedge clk) begin
    if (reset) begin
      fidx = 0; cur = 0; icyc = 0; dcyc = 0; ireq_q = 0;
      imem_ack = 0; dmem_ack = 0;
    end else begin
      if (imem_req) begin
        if (!ireq_q) begin
          cur = (fidx < 8) ? fidx : 7;
          fidx++;
          icyc = 0;
        end
        icyc++;
        imem_ack = (icyc == p_idly[cur]);
      end else begin
        imem_ack = stray_iack;
      end
      ireq_q = imem_req;
      if (dmem_req) begin
        dcyc++;
        dmem_ack = (dcyc == p_ddly[cur]);
      end else begin
        dcyc = 0;
        dmem_ack = stray_dack;
      end
    end
    icode       = p_icode[cur];
    instr_valid = p_valid[cur];
    imem_error  = p_ierr[cur];
    dmem_error  = p_derr[cur];
    pc_next     = p_npc[cur];
  end

  // Observation tallies read by the scenario tasks.
  int dec_cnt = 0, drun = 0, last_drun = 0, en_bad = 0;
  bit dreq_q = 0, wb_follow = 0;
  always @(negedge clk) begin
    if (reset) begin
      dec_cnt = 0; drun = 0; last_drun = 0; dreq_q = 0; wb_follow = 0;
    end else begin
      if (decode_en) dec_cnt++;
      if (dmem_req) drun++;
      else if (dreq_q) begin
        last_drun = drun;
        wb_follow = wb_en;
        drun = 0;
      end
      dreq_q = dmem_req;
      if ($countones({fetch_en, decode_en, execute_en, memory_en, wb_en}) > 1)
        en_bad++;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 8; i++) begin
      p_icode[i] = 4'h0; p_valid[i] = 1; p_ierr[i] = 0; p_derr[i] = 0;
      p_idly[i] = 1; p_ddly[i] = 1; p_npc[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Reset, start, count busy cycles until HALT, then settle one cycle.
  task automatic run_prog(output int n);
    do_reset();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (!halted && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Reference: walk the program applying the stage timing rules.
  task automatic model(output logic [2:0] st, output logic [63:0] mpc,
                       output int ic, output int cyc, output int dec);
    st = 3'd1; mpc = 64'h0; ic = 0; cyc = 0; dec = 0;
    for (int i = 0; i < 8; i++) begin
      if (p_idly[i] > TMO) begin cyc += TMO; st = 3'd3; break; end
      cyc += p_idly[i];
      if (p_ierr[i]) begin st = 3'd3; break; end
      if (!p_valid[i]) begin st = 3'd4; break; end
      cyc += 2; dec++;
      if (p_icode[i] inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        if (p_ddly[i] > TMO) begin cyc += TMO; st = 3'd3; break; end
        cyc += p_ddly[i];
        if (p_derr[i]) begin st = 3'd3; break; end
      end else begin
        cyc += 1;
      end
      cyc += 2;
      mpc = p_npc[i];
      ic++;
      if (p_icode[i] == 4'h0) begin st = 3'd2; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en,
         wb_en, halted} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 00000000",
               {imem_req, dmem_req, fetch_en, decode_en, execute_en,
                memory_en, wb_en, halted});
    end
    vectors++;
    if (pc !== 64'h0 || stat !== 3'd1) begin
      miscompares++;
      $display("FAIL reset_pc_stat: got pc=%0h stat=%0d want 0/1", pc, stat);
    end
    vectors++;
    if (cycle_cnt !== 0 || instr_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
    end
  endtask

  task automatic test_basic_program();
    int n;
    clear_prog();
    p_icode[0] = 4'h3; p_npc[0] = 64'd10;
    p_icode[1] = 4'h0; p_npc[1] = 64'd11;
    run_prog(n);
    vectors++;
    if (n !== 12) begin
      miscompares++;
      $display("FAIL basic_cycles: got %0d want 12", n);
    end
    vectors++;
    if (halted !== 1 || stat !== 3'd2 || pc !== 64'd11 || instr_cnt !== 2) begin
      miscompares++;
      $display("FAIL basic_final: got h=%b stat=%0d pc=%0h ic=%0d want 1/2/b/2",
               halted, stat, pc, instr_cnt);
    end
    vectors++;
    if (cycle_cnt !== 12) begin
      miscompares++;
      $display("FAIL basic_cycle_cnt: got %0d want 12", cycle_cnt);
    end
  endtask

  task automatic test_dmem_wait();
    int n;
    clear_prog();
    p_icode[0] = 4'h5; p_ddly[0] = 4; p_npc[0] = 64'd10;
    p_icode[1] = 4'h0; p_npc[1] = 64'd11;
    run_prog(n);
    vectors++;
    if (last_drun !== 4 || wb_follow !== 1) begin
      miscompares++;
      $display("FAIL dmem_wait: got run=%0d wb=%b want 4/1", last_drun, wb_follow);
    end
    vectors++;
    if (stat !== 3'd2 || n !== 15) begin
      miscompares++;
      $display("FAIL dmem_wait_final: got stat=%0d cyc=%0d want 2/15", stat, n);
    end
  endtask

  task automatic test_invalid();
    int n;
    clear_prog();
    p_icode[0] = 4'h6; p_valid[0] = 0; p_npc[0] = 64'd2;
    run_prog(n);
    vectors++;
    if (stat !== 3'd4 || halted !== 1 || pc !== 64'h0) begin
      miscompares++;
      $display("FAIL invalid_stat: got stat=%0d h=%b pc=%0h want 4/1/0",
               stat, halted, pc);
    end
    vectors++;
    if (instr_cnt !== 0 || dec_cnt !== 0) begin
      miscompares++;
      $display("FAIL invalid_nodecode: got ic=%0d dec=%0d want 0/0",
               instr_cnt, dec_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_prog();
    p_icode[0] = 4'h4; p_ddly[0] = 100; p_npc[0] = 64'd10;
    p_icode[1] = 4'h0; p_npc[1] = 64'd11;
    run_prog(n);
    vectors++;
    if (last_drun !== TMO || stat !== 3'd3 || instr_cnt !== 0 || pc !== 0) begin
      miscompares++;
      $display("FAIL timeout_fault: got run=%0d stat=%0d ic=%0d pc=%0h want 16/3/0/0",
               last_drun, stat, instr_cnt, pc);
    end
    p_ddly[0] = TMO;
    run_prog(n);
    vectors++;
    if (last_drun !== TMO || stat !== 3'd2 || instr_cnt !== 2 || pc !== 64'd11) begin
      miscompares++;
      $display("FAIL timeout_ack_wins: got run=%0d stat=%0d ic=%0d pc=%0h want 16/2/2/b",
               last_drun, stat, instr_cnt, pc);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_prog();
    p_icode[0] = 4'h1; p_npc[0] = 64'd5;
    p_icode[1] = 4'h0; p_idly[1] = 100; p_npc[1] = 64'd6;
    do_reset();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    k = 0;
    while (!(imem_req && instr_cnt == 1) && k < 50) begin
      k++;
      @(negedge clk);
    end
    vectors++;
    if (!(imem_req && pc == 64'd5)) begin
      miscompares++;
      $display("FAIL reset_mid_setup: got req=%b pc=%0h want 1/5", imem_req, pc);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    vectors++;
    if (imem_req !== 0 || fetch_en !== 0 || halted !== 0 ||
        pc !== 64'h0 || stat !== 3'd1) begin
      miscompares++;
      $display("FAIL reset_mid: got req=%b f=%b h=%b pc=%0h stat=%0d want 0/0/0/0/1",
               imem_req, fetch_en, halted, pc, stat);
    end
    reset = 0;
    @(negedge clk); stray_iack = 1; stray_dack = 1;
    @(negedge clk); stray_iack = 0; stray_dack = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (fetch_en !== 0 || imem_req !== 0 || pc !== 64'h0 || stat !== 3'd1 ||
        instr_cnt !== 0 || cycle_cnt !== 0) begin
      miscompares++;
      $display("FAIL stray_ack_idle: got f=%b req=%b pc=%0h stat=%0d ic=%0d cc=%0d",
               fetch_en, imem_req, pc, stat, instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_halt_start();
    int n;
    clear_prog();
    p_icode[0] = 4'h3; p_npc[0] = 64'd10;
    p_icode[1] = 4'h0; p_npc[1] = 64'd11;
    run_prog(n);
    @(negedge clk); start = 1; stray_iack = 1;
    @(negedge clk); start = 0; stray_iack = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (halted !== 1 || fetch_en !== 0 || pc !== 64'd11 || stat !== 3'd2 ||
        cycle_cnt !== 12 || instr_cnt !== 2) begin
      miscompares++;
      $display("FAIL halt_start: got h=%b f=%b pc=%0h stat=%0d cc=%0d ic=%0d",
               halted, fetch_en, pc, stat, cycle_cnt, instr_cnt);
    end
  endtask

  task automatic test_random();
    int n, len, ic, cyc, dec;
    logic [2:0]  st;
    logic [63:0] mpc;
    for (int t = 0; t < 30; t++) begin
      clear_prog();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        p_icode[i] = (i == len - 1) ? 4'h0 : 4'($urandom_range(1, 11));
        p_valid[i] = ($urandom_range(0, 19) != 0);
        p_ierr[i]  = ($urandom_range(0, 29) == 0);
        p_derr[i]  = ($urandom_range(0, 19) == 0);
        p_idly[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, TMO + 3)
                                                 : $urandom_range(1, 3);
        p_ddly[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, TMO + 3)
                                                 : $urandom_range(1, 4);
        p_npc[i]   = {$urandom, $urandom};
      end
      model(st, mpc, ic, cyc, dec);
      run_prog(n);
      vectors++;
      if (halted !== 1 || stat !== st) begin
        miscompares++;
        $display("FAIL rand%0d_stat: got h=%b stat=%0d want 1/%0d", t, halted, stat, st);
      end
      vectors++;
      if (pc !== mpc) begin
        miscompares++;
        $display("FAIL rand%0d_pc: got %h want %h", t, pc, mpc);
      end
      vectors++;
      if (instr_cnt !== ic) begin
        miscompares++;
        $display("FAIL rand%0d_instr_cnt: got %0d want %0d", t, instr_cnt, ic);
      end
      vectors++;
      if (cycle_cnt !== cyc || n !== cyc) begin
        miscompares++;
        $display("FAIL rand%0d_cycles: got cc=%0d obs=%0d want %0d", t, cycle_cnt, n, cyc);
      end
      vectors++;
      if (dec_cnt !== dec) begin
        miscompares++;
        $display("FAIL rand%0d_decodes: got %0d want %0d", t, dec_cnt, dec);
      end
    end
    vectors++;
    if (en_bad !== 0) begin
      miscompares++;
      $display("FAIL strobe_onehot: got %0d multi-strobe cycles want 0", en_bad);
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_basic_program();
    test_dmem_wait();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_halt_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
